// File: rtl/nrzi_pkg.sv
// -----------------------------------------------------------------------------
// nrzi_pkg
// Shared definitions for the transition-coded line receiver (and the future
// encoder that produces the same line code).
//   state_t            : receiver FSM states
//   SYNC_PAT_DEFAULT   : decoded sync word, LSB-first (bits 0,0,0,0,0,0,0,1)
//   STUFF_LEN_DEFAULT  : run of decoded 1s after which a stuffed 0 is mandatory
//   IDLE_LEVEL         : line level when idle (J state)
// -----------------------------------------------------------------------------
package nrzi_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_PAT_DEFAULT  = 8'h80;
  localparam int         STUFF_LEN_DEFAULT = 6;
  localparam logic       IDLE_LEVEL        = 1'b1;

endpackage : nrzi_pkg

// File: rtl/nrzi_bit_decode.sv
// -----------------------------------------------------------------------------
// nrzi_bit_decode
// Converts line samples into decoded bits: a transition decodes to 0, no
// transition decodes to 1. Holds the previous line level.
// Ports:
//   clock    : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   bit_vld  : line_in carries a valid bit-time sample
//   line_in  : sampled line level
//   eop_in   : end-of-packet; drops any coincident sample and restores idle
//   dbit     : decoded bit (meaningful when dbit_vld is high)
//   dbit_vld : a decoded bit is available this cycle
// -----------------------------------------------------------------------------
module nrzi_bit_decode
  import nrzi_pkg::*;
(
  input  logic clock,
  input  logic rst,
  input  logic bit_vld,
  input  logic line_in,
  input  logic eop_in,
  output logic dbit,
  output logic dbit_vld
);

  logic r_prev_line;

  assign dbit     = ~(line_in ^ r_prev_line);
  // eop wins over a simultaneous sample; that sample is never decoded.
  assign dbit_vld = bit_vld & ~eop_in;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_prev_line <= IDLE_LEVEL;
    end else if (eop_in) begin
      // Next packet's sync is decoded relative to the idle level.
      r_prev_line <= IDLE_LEVEL;
    end else if (bit_vld) begin
      r_prev_line <= line_in;
    end
  end

endmodule : nrzi_bit_decode

// File: rtl/nrzi_rx_decoder.sv
// -----------------------------------------------------------------------------
// nrzi_rx_decoder
// Transition-coded serial receiver: hunts for the sync word, removes stuffed
// bits, assembles LSB-first words and flags frame boundaries and errors.
// Ports:
//   clock, rst   : clock and synchronous active-high reset
//   bit_vld      : line_in valid this cycle
//   line_in      : sampled line level
//   eop_in       : end-of-packet pulse from the PHY
//   data_out     : last assembled word
//   data_valid   : pulse, data_out is new
//   frame_start  : pulse on sync match
//   frame_end    : pulse on eop_in while receiving data
//   stuff_err    : pulse on a stuffing violation
//   align_err    : pulse when a frame ends with a partial word
//   busy         : high while in DATA or ERR
// All pulses appear one cycle after the triggering input cycle.
// -----------------------------------------------------------------------------
module nrzi_rx_decoder
  import nrzi_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter logic [7:0] SYNC_PAT  = SYNC_PAT_DEFAULT
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              bit_vld,
  input  logic              line_in,
  input  logic              eop_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              stuff_err,
  output logic              align_err,
  output logic              busy
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam int OCNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(DATA_W - 1);
  localparam logic [OCNT_W-1:0] STUFF_MAX = OCNT_W'(STUFF_LEN);

  logic w_dbit;
  logic w_dbit_vld;

  nrzi_bit_decode u_bit_decode (
    .clock    (clock),
    .rst      (rst),
    .bit_vld  (bit_vld),
    .line_in  (line_in),
    .eop_in   (eop_in),
    .dbit     (w_dbit),
    .dbit_vld (w_dbit_vld)
  );

  // State registers
  state_t              r_state,       r_state_next;
  logic [7:0]          r_sync_sr,     r_sync_sr_next;
  logic [DATA_W-1:0]   r_word_sr,     r_word_sr_next;
  logic [BCNT_W-1:0]   r_bcnt,        r_bcnt_next;
  logic [OCNT_W-1:0]   r_ones,        r_ones_next;
  logic [DATA_W-1:0]   r_data_out,    r_data_out_next;
  logic                r_data_valid,  r_data_valid_next;
  logic                r_frame_start, r_frame_start_next;
  logic                r_frame_end,   r_frame_end_next;
  logic                r_stuff_err,   r_stuff_err_next;
  logic                r_align_err,   r_align_err_next;
  logic                r_busy;

  // New bit enters at the MSB so the first received bit ends up at the LSB.
  logic [7:0]        w_sync_shift;
  logic [DATA_W-1:0] w_word_shift;
  assign w_sync_shift = {w_dbit, r_sync_sr[7:1]};
  assign w_word_shift = {w_dbit, r_word_sr[DATA_W-1:1]};

  always_comb begin
    r_state_next       = r_state;
    r_sync_sr_next     = r_sync_sr;
    r_word_sr_next     = r_word_sr;
    r_bcnt_next        = r_bcnt;
    r_ones_next        = r_ones;
    r_data_out_next    = r_data_out;
    r_data_valid_next  = 1'b0;
    r_frame_start_next = 1'b0;
    r_frame_end_next   = 1'b0;
    r_stuff_err_next   = 1'b0;
    r_align_err_next   = 1'b0;

    if (eop_in) begin
      if (r_state == DATA) begin
        r_frame_end_next = 1'b1;
        r_align_err_next = (r_bcnt != '0);
      end
      r_state_next   = HUNT;
      r_sync_sr_next = '0;
      r_word_sr_next = '0;
      r_bcnt_next    = '0;
      r_ones_next    = '0;
    end else if (w_dbit_vld) begin
      case (r_state)
        HUNT: begin
          r_sync_sr_next = w_sync_shift;
          if (w_sync_shift == SYNC_PAT) begin
            r_frame_start_next = 1'b1;
            r_state_next       = DATA;
            r_sync_sr_next     = '0;
            r_word_sr_next     = '0;
            r_bcnt_next        = '0;
            // The sync's trailing 1 starts the run toward a mandatory stuff.
            r_ones_next        = OCNT_W'(1);
          end
        end
        DATA: begin
          if (r_ones == STUFF_MAX) begin
            // This bit position must carry a stuffed 0.
            if (w_dbit) begin
              r_stuff_err_next = 1'b1;
              r_state_next     = ERR;
            end else begin
              r_ones_next = '0;
            end
          end else begin
            r_word_sr_next = w_word_shift;
            r_ones_next    = w_dbit ? (r_ones + OCNT_W'(1)) : '0;
            if (r_bcnt == LAST_BIT) begin
              r_data_out_next   = w_word_shift;
              r_data_valid_next = 1'b1;
              r_bcnt_next       = '0;
            end else begin
              r_bcnt_next = r_bcnt + BCNT_W'(1);
            end
          end
        end
        ERR: begin
          // Bits are ignored until eop returns the receiver to HUNT.
        end
        default: begin
          r_state_next = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state       <= HUNT;
      r_sync_sr     <= '0;
      r_word_sr     <= '0;
      r_bcnt        <= '0;
      r_ones        <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_stuff_err   <= 1'b0;
      r_align_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= r_state_next;
      r_sync_sr     <= r_sync_sr_next;
      r_word_sr     <= r_word_sr_next;
      r_bcnt        <= r_bcnt_next;
      r_ones        <= r_ones_next;
      r_data_out    <= r_data_out_next;
      r_data_valid  <= r_data_valid_next;
      r_frame_start <= r_frame_start_next;
      r_frame_end   <= r_frame_end_next;
      r_stuff_err   <= r_stuff_err_next;
      r_align_err   <= r_align_err_next;
      r_busy        <= (r_state_next != HUNT);
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign stuff_err   = r_stuff_err;
  assign align_err   = r_align_err;
  assign busy        = r_busy;

endmodule : nrzi_rx_decoder

// File: tb/tb_nrzi_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_nrzi_rx_decoder
// Scoreboard bench: the stimulus pushes expected pulse events (kind, cycle,
// data) into a queue; a monitor on the falling edge pops and compares every
// pulse the receiver presents, and flags expected pulses that never arrive.
// -----------------------------------------------------------------------------
module tb_nrzi_rx_decoder;

  localparam int K_START = 0;
  localparam int K_DATA  = 1;
  localparam int K_STUFF = 2;
  localparam int K_END   = 3;
  localparam int K_ALIGN = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       rst;
  logic       bit_vld;
  logic       line_in;
  logic       eop_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       frame_end;
  logic       stuff_err;
  logic       align_err;
  logic       busy;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic tb_line = 1'b1;
  ev_t  exp_q[$];

  nrzi_rx_decoder dut (
    .clock       (clock),
    .rst         (rst),
    .bit_vld     (bit_vld),
    .line_in     (line_in),
    .eop_in      (eop_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .stuff_err   (stuff_err),
    .align_err   (align_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_START: return "frame_start";
      K_DATA:  return "data_valid";
      K_STUFF: return "stuff_err";
      K_END:   return "frame_end";
      default: return "align_err";
    endcase
  endfunction

  // Expected pulse one cycle after the input cycle just driven.
  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc + 1;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic void check_ev(input int k);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s cyc=%0d got=1 exp=0", kname(k), cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.cyc != cyc || (k == K_DATA && data_out != e.data)) begin
      bad++;
      $display("FAIL %s cyc=%0d data=%h got_kind=%s exp_kind=%s exp_cyc=%0d exp_data=%h",
               kname(k), cyc, data_out, kname(k), kname(e.kind), e.cyc, e.data);
    end else begin
      $display("txn %s cyc=%0d data=%h ok", kname(k), cyc, data_out);
    end
  endfunction

  // Monitor: pulses are compared in a fixed order matching the push order.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_%s cyc=%0d got=0 exp=1", kname(exp_q[0].kind), exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (frame_start) check_ev(K_START);
    if (data_valid)  check_ev(K_DATA);
    if (stuff_err)   check_ev(K_STUFF);
    if (frame_end)   check_ev(K_END);
    if (align_err)   check_ev(K_ALIGN);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end else begin
      $display("txn check %s=%h ok", nm, got);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h0);
    chk({tag, "_pulses"}, 32'({data_valid, frame_start, frame_end, stuff_err, align_err}), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic tx_level(input logic lvl);
    @(negedge clock);
    bit_vld = 1'b1;
    line_in = lvl;
    eop_in  = 1'b0;
    tb_line = lvl;
  endtask

  // Encode a decoded bit into a line level: 0 toggles, 1 holds.
  task automatic tx_dbit(input logic b);
    tx_level(b ? tb_line : ~tb_line);
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_dbit(v[i]);
  endtask

  task automatic tx_sync();
    tx_byte(8'h80);
    expect_ev(K_START, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bit_vld = 1'b0;
      eop_in  = 1'b0;
    end
  endtask

  task automatic eop_cycle(input logic vld, input logic lvl);
    @(negedge clock);
    bit_vld = vld;
    line_in = lvl;
    eop_in  = 1'b1;
    tb_line = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lv;
    rst = 1'b1; bit_vld = 1'b0; line_in = 1'b1; eop_in = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // 1) sync then zero byte, using the literal line levels
    lv = 16'b0101010001010101; // bit 15 first: 0,1,0,1,0,1,0,0,0 ... see loop
    lv = {8'b01010100, 8'b10101010};
    for (int i = 15; i >= 0; i--) begin
      tx_level(lv[i]);
      if (i == 8) expect_ev(K_START, 8'h00);
      if (i == 0) expect_ev(K_DATA, 8'h00);
    end
    idle(1);
    chk("t1_busy", 32'(busy), 32'h1);
    eop_cycle(1'b0, 1'b1);
    expect_ev(K_END, 8'h00);
    idle(2);
    chk("t1_busy_after_eop", 32'(busy), 32'h0);

    // 2) stuffing: five 1s reach the run limit, stuffed 0 dropped; back-to-back byte
    tx_sync();
    repeat (5) tx_dbit(1'b1);
    tx_dbit(1'b0);
    repeat (3) tx_dbit(1'b1);
    expect_ev(K_DATA, 8'hFF);
    tx_byte(8'h5A);
    expect_ev(K_DATA, 8'h5A);
    eop_cycle(1'b0, 1'b1);
    expect_ev(K_END, 8'h00);
    idle(2);

    // 3) stuff violation: sixth held sample is a 1 where a stuffed 0 is required
    tx_sync();
    repeat (5) tx_dbit(1'b1);
    tx_dbit(1'b1);
    expect_ev(K_STUFF, 8'h00);
    repeat (3) tx_dbit(1'b1);
    idle(2);
    chk("t3_busy_in_err", 32'(busy), 32'h1);
    eop_cycle(1'b0, 1'b1);
    idle(1);
    chk("t3_busy_after_eop", 32'(busy), 32'h0);
    idle(1);

    // 4) partial word with gaps between samples
    tx_sync();
    tx_dbit(1'b1);
    idle(2);
    tx_dbit(1'b0);
    idle(1);
    tx_dbit(1'b1);
    eop_cycle(1'b0, 1'b1);
    expect_ev(K_END, 8'h00);
    expect_ev(K_ALIGN, 8'h00);
    idle(2);

    // 5) eop coincident with a sample: sample dropped, next sync from idle level
    tx_sync();
    tx_dbit(1'b1); tx_dbit(1'b1); tx_dbit(1'b0); tx_dbit(1'b0);
    eop_cycle(1'b1, 1'b0);
    expect_ev(K_END, 8'h00);
    expect_ev(K_ALIGN, 8'h00);
    idle(1);
    tx_sync();
    tx_byte(8'h3C);
    expect_ev(K_DATA, 8'h3C);
    idle(1);
    chk("t5_data_out_hold", 32'(data_out), 32'h3C);
    eop_cycle(1'b0, 1'b1);
    expect_ev(K_END, 8'h00);
    idle(2);

    // 6) reset mid-frame, then a clean frame
    tx_sync();
    tx_dbit(1'b1); tx_dbit(1'b0); tx_dbit(1'b1); tx_dbit(1'b1);
    @(negedge clock);
    bit_vld = 1'b0;
    rst     = 1'b1;
    @(negedge clock);
    rst     = 1'b0;
    tb_line = 1'b1;
    chk_all_zero("midrst");
    idle(1);
    tx_sync();
    tx_byte(8'hA5);
    expect_ev(K_DATA, 8'hA5);
    eop_cycle(1'b0, 1'b1);
    expect_ev(K_END, 8'h00);
    idle(4);

    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missing_%s cyc=%0d got=0 exp=1", kname(exp_q[0].kind), exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nrzi_rx_decoder
